// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Pixel-enable divider and 800x525 raster sweep producing hCount,
//            vCount, active-low syncs, bright window and per-frame game tick.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_TOTAL   = 800,
    parameter int H_SYNC    = 96,
    parameter int H_ACT_BEG = 144,
    parameter int H_ACT_END = 784,
    parameter int V_TOTAL   = 525,
    parameter int V_SYNC    = 2,
    parameter int V_ACT_BEG = 35,
    parameter int V_ACT_END = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);

    localparam logic [3:0] c_DIV_MAX   = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_SYNC    = 10'(H_SYNC);
    localparam logic [9:0] c_V_SYNC    = 10'(V_SYNC);
    localparam logic [9:0] c_H_ACT_BEG = 10'(H_ACT_BEG);
    localparam logic [9:0] c_H_ACT_END = 10'(H_ACT_END);
    localparam logic [9:0] c_V_ACT_BEG = 10'(V_ACT_BEG);
    localparam logic [9:0] c_V_ACT_END = 10'(V_ACT_END);

    logic [3:0] r_div_cnt;
    logic [3:0] w_div_next;
    logic       w_adv;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    // Counters advance on the edge that ends the cycle where the divider is
    // at its last count; pix_en is that same condition presented as a register.
    assign w_adv = (r_div_cnt == c_DIV_MAX);

    always_comb begin
        w_div_next = w_adv ? 4'd0 : r_div_cnt + 4'd1;
        w_h_next   = hCount;
        w_v_next   = vCount;
        if (w_adv) begin
            if (hCount == c_H_LAST) begin
                w_h_next = 10'd0;
                w_v_next = (vCount == c_V_LAST) ? 10'd0 : vCount + 10'd1;
            end else begin
                w_h_next = hCount + 10'd1;
            end
        end
    end

    // Decodes use next-count values so they line up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= 4'd0;
            pix_en     <= 1'b0;
            hCount     <= 10'd0;
            vCount     <= 10'd0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_next;
            pix_en     <= (w_div_next == c_DIV_MAX);
            hCount     <= w_h_next;
            vCount     <= w_v_next;
            hSync      <= (w_h_next >= c_H_SYNC);
            vSync      <= (w_v_next >= c_V_SYNC);
            bright     <= (w_h_next >= c_H_ACT_BEG) && (w_h_next < c_H_ACT_END) &&
                          (w_v_next >= c_V_ACT_BEG) && (w_v_next < c_V_ACT_END);
            frame_tick <= w_adv && (w_h_next == 10'd0) && (w_v_next == c_V_ACT_END);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen on a reduced raster, with a
//            second instance at CLK_DIV=1, against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HT  = 40;
    localparam int HS  = 5;
    localparam int HAB = 8;
    localparam int HAE = 36;
    localparam int VT  = 20;
    localparam int VS  = 2;
    localparam int VAB = 4;
    localparam int VAE = 17;
    localparam int FRAME_CLKS = HT * VT * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en, hSync, vSync, bright, frame_tick;
    logic [9:0] hCount, vCount;
    logic       pix_en1, hSync1, vSync1, bright1, frame_tick1;
    logic [9:0] hCount1, vCount1;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // edges with rst low since the last reset edge
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_BEG(HAB), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_BEG(VAB), .V_ACT_END(VAE)
    ) u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright), .frame_tick(frame_tick)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_BEG(HAB), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_BEG(VAB), .V_ACT_END(VAE)
    ) u_dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en1), .hCount(hCount1), .vCount(vCount1),
        .hSync(hSync1), .vSync(vSync1), .bright(bright1), .frame_tick(frame_tick1)
    );

    wire [24:0] obs  = {pix_en, hCount, vCount, hSync, vSync, bright, frame_tick};
    wire [24:0] obs1 = {pix_en1, hCount1, vCount1, hSync1, vSync1, bright1, frame_tick1};

    // Raster model: pixel index is whole pixel periods elapsed since reset.
    function automatic int m_pos(int kk, int d);
        return (kk / d) % (HT * VT);
    endfunction
    function automatic int m_h(int kk, int d);
        return m_pos(kk, d) % HT;
    endfunction
    function automatic int m_v(int kk, int d);
        return m_pos(kk, d) / HT;
    endfunction
    function automatic logic [24:0] m_vec(int kk, int d);
        int h, v;
        logic pe, hs, vs, br, ft;
        h  = m_h(kk, d);
        v  = m_v(kk, d);
        pe = (kk > 0) && (kk % d == d - 1);
        hs = (h >= HS);
        vs = (v >= VS);
        br = (h >= HAB) && (h < HAE) && (v >= VAB) && (v < VAE);
        ft = (kk > 0) && (kk % d == 0) && (m_pos(kk, d) == VAE * HT);
        return {pe, 10'(h), 10'(v), hs, vs, br, ft};
    endfunction

    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        k   = r ? 0 : k + 1;
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic run_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(m_h(k, D) == h && m_v(k, D) == v) && guard < 2 * FRAME_CLKS) begin
            tick(1'b0);
            guard++;
        end
        n_cmp++;
        if (hCount !== 10'(h) || vCount !== 10'(v)) begin
            n_bad++;
            $display("FAIL run_to: got (%0d,%0d) required (%0d,%0d)", hCount, vCount, h, v);
        end
    endtask

    task automatic test_reset;
        repeat (3) tick(1'b1);
        n_cmp++;
        if (obs !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h required 0", obs);
        end
        tick(1'b0);
        n_cmp++;
        if (pix_en !== 1'b0 || hCount !== 10'd0) begin
            n_bad++;
            $display("FAIL pix_en_clk2: got pe=%b h=%0d required pe=0 h=0", pix_en, hCount);
        end
        n_cmp++;
        if (pix_en1 !== 1'b1 || hCount1 !== 10'd1) begin
            n_bad++;
            $display("FAIL div1_first: got pe=%b h=%0d required pe=1 h=1", pix_en1, hCount1);
        end
        tick(1'b0);
        n_cmp++;
        if (pix_en !== 1'b1 || hCount !== 10'd0) begin
            n_bad++;
            $display("FAIL pix_en_first: got pe=%b h=%0d required pe=1 h=0", pix_en, hCount);
        end
        tick(1'b0);
        n_cmp++;
        if (pix_en !== 1'b0 || hCount !== 10'd1 || vCount !== 10'd0) begin
            n_bad++;
            $display("FAIL first_inc: got pe=%b h=%0d v=%0d required pe=0 h=1 v=0",
                     pix_en, hCount, vCount);
        end
    endtask

    task automatic test_sync;
        run_to(HS - 1, 0);
        n_cmp++;
        if (hSync !== 1'b0 || vSync !== 1'b0) begin
            n_bad++;
            $display("FAIL hsync_before: got hs=%b vs=%b required 0 0", hSync, vSync);
        end
        repeat (D) tick(1'b0);
        n_cmp++;
        if (hCount !== 10'(HS) || hSync !== 1'b1) begin
            n_bad++;
            $display("FAIL hsync_rise: got h=%0d hs=%b required h=%0d hs=1", hCount, hSync, HS);
        end
        run_to(0, VS - 1);
        n_cmp++;
        if (vSync !== 1'b0) begin
            n_bad++;
            $display("FAIL vsync_low: got %b required 0", vSync);
        end
        run_to(0, VS);
        n_cmp++;
        if (vSync !== 1'b1) begin
            n_bad++;
            $display("FAIL vsync_high: got %b required 1", vSync);
        end
    endtask

    task automatic test_bright;
        int ph[6] = '{HAB - 1, HAB, HAE - 1, HAE, 20, 20};
        int pv[6] = '{VAB, VAB, VAB, VAB, VAE - 1, VAE};
        logic pb[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_to(ph[i], pv[i]);
            n_cmp++;
            if (bright !== pb[i]) begin
                n_bad++;
                $display("FAIL bright_%0d_%0d: got %b required %b", ph[i], pv[i], bright, pb[i]);
            end
        end
    endtask

    task automatic test_wrap;
        run_to(HT - 1, 10);
        repeat (D) tick(1'b0);
        n_cmp++;
        if (hCount !== 10'd0 || vCount !== 10'd11) begin
            n_bad++;
            $display("FAIL line_wrap: got (%0d,%0d) required (0,11)", hCount, vCount);
        end
        run_to(HT - 1, VT - 1);
        repeat (D) tick(1'b0);
        n_cmp++;
        if (hCount !== 10'd0 || vCount !== 10'd0) begin
            n_bad++;
            $display("FAIL frame_wrap: got (%0d,%0d) required (0,0)", hCount, vCount);
        end
    endtask

    task automatic test_frame_tick;
        int n_hi, t0, t1, bad_pos;
        n_hi = 0; t0 = -1; t1 = -1; bad_pos = 0;
        tick(1'b1);
        for (int i = 0; i < 2 * FRAME_CLKS + 50; i++) begin
            tick(1'b0);
            if (frame_tick === 1'b1) begin
                n_hi++;
                if (t0 < 0) t0 = cyc; else if (t1 < 0) t1 = cyc;
                if (hCount !== 10'd0 || vCount !== 10'(VAE)) bad_pos++;
            end
        end
        n_cmp++;
        if (n_hi !== 2) begin
            n_bad++;
            $display("FAIL tick_count: got %0d high clks required 2", n_hi);
        end
        n_cmp++;
        if (t1 - t0 !== FRAME_CLKS) begin
            n_bad++;
            $display("FAIL tick_period: got %0d required %0d", t1 - t0, FRAME_CLKS);
        end
        n_cmp++;
        if (bad_pos !== 0) begin
            n_bad++;
            $display("FAIL tick_pos: got %0d ticks off (0,%0d) required 0", bad_pos, VAE);
        end
    endtask

    task automatic test_mid_reset;
        run_to(20, 12);
        tick(1'b1);
        n_cmp++;
        if (obs !== 25'd0 || obs1 !== 25'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h / %h required 0 / 0", obs, obs1);
        end
        tick(1'b0);
        tick(1'b0);
        n_cmp++;
        if (pix_en !== 1'b1 || hCount !== 10'd0 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_pe: got pe=%b h=%0d ft=%b required pe=1 h=0 ft=0",
                     pix_en, hCount, frame_tick);
        end
        tick(1'b0);
        n_cmp++;
        if (hCount !== 10'd1 || vCount !== 10'd0) begin
            n_bad++;
            $display("FAIL resume_inc: got (%0d,%0d) required (1,0)", hCount, vCount);
        end
    endtask

    task automatic test_random;
        int len;
        for (int it = 0; it < 8; it++) begin
            len = (it == 7) ? FRAME_CLKS + 100 : int'($urandom_range(20, 1500));
            for (int c = 0; c < len; c++) begin
                tick(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
                n_cmp++;
                if (obs !== m_vec(k, D)) begin
                    n_bad++;
                    $display("FAIL rand_div%0d k=%0d: got %h required %h", D, k, obs, m_vec(k, D));
                end
                n_cmp++;
                if (obs1 !== m_vec(k, 1)) begin
                    n_bad++;
                    $display("FAIL rand_div1 k=%0d: got %h required %h", k, obs1, m_vec(k, 1));
                end
            end
            repeat ($urandom_range(1, 3)) tick(1'b1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sync();
        test_bright();
        test_wrap();
        test_frame_tick();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
